// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin (or fixed-priority) AHB bus arbiter with burst and lock hold, parks on master 0.
// Latency: HGRANT registered one cycle after the arbitration-point edge; HMASTER follows at the next HREADY=1 edge.
// Backpressure: HREADY=0 freezes grant, beat counter, FSM, HMASTER and HMASTLOCK.
//
// Optional feature macro: AHB_ARB_RR_EN (defined = rotating round-robin pointer, undefined = lowest index wins).
// Ports:
//   HCLK, HRESET       clock, synchronous active-high reset
//   HBUSREQ, HLOCK     per-master bus request / locked-transfer request
//   HTRANS, HBURST     muxed transfer type and burst type of the current owner
//   HREADY             muxed bus ready
//   HGRANT             registered one-hot grant
//   HMASTER            address-phase owner index (bus mux select)
//   HMASTLOCK          current owner's transfer is locked
module ahb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MW          = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);

  typedef enum logic [1:0] {ARB, BURST, LOCK} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic [MW-1:0]            gnt_idx_q, gnt_idx_d;
  logic [NUM_MASTERS-1:0]   grant_d;
  logic                     arb_pt;
  logic                     win_vld;
  logic [MW-1:0]            win_idx;
  logic                     trans_ns, trans_sq, trans_idle, fixed_burst;

  assign trans_ns    = (HTRANS == 2'b10);
  assign trans_sq    = (HTRANS == 2'b11);
  assign trans_idle  = (HTRANS == 2'b00);
  assign fixed_burst = (HBURST[2:1] != 2'b00);

  // Remaining beats after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] burst_len(input logic [2:0] b);
    case (b)
      3'b010, 3'b011: burst_len = 4'd3;
      3'b100, 3'b101: burst_len = 4'd7;
      3'b110, 3'b111: burst_len = 4'd15;
      default:        burst_len = 4'd0;
    endcase
  endfunction

`ifdef AHB_ARB_RR_EN
  logic [MW-1:0] ptr_q, ptr_d;

  function automatic logic [MW-1:0] rr_idx(input logic [MW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return MW'(s);
  endfunction

  // First requester scanning upward from the pointer, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!win_vld && HBUSREQ[rr_idx(ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(ptr_q, i);
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Lowest requesting index wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (HBUSREQ[i]) begin
        win_vld = 1'b1;
        win_idx = MW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_idx_d = gnt_idx_q;
    arb_pt    = 1'b0;
`ifdef AHB_ARB_RR_EN
    ptr_d     = ptr_q;
`endif
    if (HREADY) begin
      case (state_q)
        ARB: begin
          if (trans_ns && fixed_burst) begin
            state_d = BURST;
            cnt_d   = burst_len(HBURST);
          end else if (!(trans_sq && fixed_burst)) begin
            // A stray SEQ of a fixed burst seen in ARB is not a safe point to move.
            arb_pt = 1'b1;
          end
        end
        BURST: begin
          if (trans_sq) begin
            if (cnt_q == 4'd1) begin
              arb_pt  = 1'b1;
              cnt_d   = '0;
              state_d = ARB;
            end else begin
              cnt_d = cnt_q - 4'd1;
            end
          end else if (trans_idle) begin
            arb_pt  = 1'b1;
            cnt_d   = '0;
            state_d = ARB;
          end else if (trans_ns) begin
            if (fixed_burst) begin
              cnt_d = burst_len(HBURST);
            end else begin
              arb_pt  = 1'b1;
              cnt_d   = '0;
              state_d = ARB;
            end
          end
          // BUSY: hold counter and grant
        end
        LOCK: begin
          if (!HLOCK[gnt_idx_q]) begin
            arb_pt  = 1'b1;
            state_d = ARB;
          end
        end
        default: state_d = ARB;
      endcase
    end

    if (arb_pt) begin
      if (HLOCK[gnt_idx_q]) begin
        // Owner keeps the bus for its locked sequence; pointer untouched.
        state_d = LOCK;
        cnt_d   = '0;
      end else if (win_vld) begin
        gnt_idx_d = win_idx;
`ifdef AHB_ARB_RR_EN
        ptr_d = (win_idx == MW'(NUM_MASTERS - 1)) ? '0 : win_idx + MW'(1);
`endif
      end else begin
        gnt_idx_d = '0;
      end
    end

    grant_d            = '0;
    grant_d[gnt_idx_d] = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ARB;
      cnt_q     <= '0;
      gnt_idx_q <= '0;
      HGRANT    <= NUM_MASTERS'(1);
      HMASTER   <= '0;
      HMASTLOCK <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_idx_q <= gnt_idx_d;
      HGRANT    <= grant_d;
      if (HREADY) begin
        HMASTER   <= gnt_idx_q;
        HMASTLOCK <= HLOCK[gnt_idx_q];
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed-vector bench for ahb_arbiter with a queued scoreboard.
// Latency: each expectation is tagged with the clock edge after which it must hold.
// Backpressure: HREADY stalls are part of the directed vectors.
module tb_ahb_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SQ   = 2'b11;
  localparam logic [2:0] B_SGL  = 3'b000;
  localparam logic [2:0] B_I4   = 3'b011;
  localparam logic [2:0] B_I8   = 3'b101;
  localparam logic [2:0] B_W16  = 3'b110;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [3:0] HBUSREQ = '0;
  logic [3:0] HLOCK = '0;
  logic [1:0] HTRANS = T_IDLE;
  logic [2:0] HBURST = B_SGL;
  logic       HREADY = 1'b1;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  ahb_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int         tag;
    logic [3:0] gnt;
    logic [1:0] mst;
    logic       mlk;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  // Monitor: after each edge, compare every expectation due at this edge.
  always @(posedge HCLK) begin
    exp_t e;
    #1;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.tag < cyc) begin
        n_fail++;
        $display("FAIL %s stale expectation: due edge %0d, now edge %0d", e.name, e.tag, cyc);
      end else begin
        if (HGRANT !== e.gnt) begin
          n_fail++;
          $display("FAIL %s HGRANT got %b expected %b", e.name, HGRANT, e.gnt);
        end
        n_checks++;
        if (HMASTER !== e.mst) begin
          n_fail++;
          $display("FAIL %s HMASTER got %0d expected %0d", e.name, HMASTER, e.mst);
        end
        n_checks++;
        if (HMASTLOCK !== e.mlk) begin
          n_fail++;
          $display("FAIL %s HMASTLOCK got %b expected %b", e.name, HMASTLOCK, e.mlk);
        end
      end
    end
  end

  task automatic step(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy, input logic rst,
                      input logic [3:0] eg, input logic [1:0] em, input logic el,
                      input string nm);
    exp_t e;
    @(negedge HCLK);
    HBUSREQ = req;
    HLOCK   = lck;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    HRESET  = rst;
    e.tag  = cyc + 1;
    e.gnt  = eg;
    e.mst  = em;
    e.mlk  = el;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    step(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] eg;
    logic [1:0] em;

    // Reset and park
    do_reset("rst0");
    do_reset("rst1");
    step(4'b0000, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b0, "park");

    // Fairness with all masters requesting SINGLE transfers
    do_reset("rr_rst");
    for (int k = 0; k < 5; k++) begin
`ifdef AHB_ARB_RR_EN
      eg = 4'b0001 << (k % 4);
      em = 2'((k == 0) ? 0 : k - 1);
`else
      eg = 4'b0001;
      em = 2'd0;
`endif
      step(4'b1111, 4'b0000, T_NS, B_SGL, 1'b1, 1'b0, eg, em, 1'b0, $sformatf("rr%0d", k));
    end

    // INCR8 owned by master 1 with one stall, master 2 waiting
    do_reset("b8_rst");
    step(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0, "b8_own");
    step(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "b8_keep");
    step(4'b0110, 4'b0000, T_NS,   B_I8,  1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "b8_ns");
    step(4'b0100, 4'b0000, T_SQ,   B_I8,  1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "b8_s1");
    step(4'b0100, 4'b0000, T_SQ,   B_I8,  1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "b8_s2");
    step(4'b0100, 4'b0000, T_SQ,   B_I8,  1'b0, 1'b0, 4'b0010, 2'd1, 1'b0, "b8_stall");
    for (int k = 3; k <= 6; k++)
      step(4'b0100, 4'b0000, T_SQ, B_I8, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, $sformatf("b8_s%0d", k));
    step(4'b0100, 4'b0000, T_SQ,   B_I8,  1'b1, 1'b0, 4'b0100, 2'd1, 1'b0, "b8_last");
    step(4'b0100, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, "b8_hand");

    // WRAP16 owned by master 3, IDLE after 5 beats
    do_reset("et_rst");
    step(4'b1000, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b1000, 2'd0, 1'b0, "et_own");
    step(4'b1000, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, "et_keep");
    step(4'b1001, 4'b0000, T_NS,   B_W16, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, "et_ns");
    for (int k = 2; k <= 5; k++)
      step(4'b1001, 4'b0000, T_SQ, B_W16, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b0, $sformatf("et_s%0d", k));
    step(4'b1001, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0001, 2'd3, 1'b0, "et_idle");
    step(4'b1000, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b1000, 2'd0, 1'b0, "et_after");

    // Locked sequence by master 0 while master 1 requests
    do_reset("lk_rst");
    step(4'b0011, 4'b0001, T_NS,   B_SGL, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, "lk1");
    step(4'b0011, 4'b0001, T_NS,   B_SGL, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, "lk2");
    step(4'b0010, 4'b0000, T_NS,   B_SGL, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, "lk_stall");
    step(4'b0011, 4'b0001, T_NS,   B_SGL, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, "lk3");
    step(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0, "lk_rel");
    step(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0, "lk_hand");

    // Reset in the middle of an INCR4 owned by master 2
    do_reset("rb_rst0");
    step(4'b0100, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0100, 2'd0, 1'b0, "rb_own");
    step(4'b0100, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, "rb_keep");
    step(4'b0110, 4'b0000, T_NS,   B_I4,  1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, "rb_ns");
    step(4'b0110, 4'b0000, T_SQ,   B_I4,  1'b1, 1'b0, 4'b0100, 2'd2, 1'b0, "rb_s2");
    step(4'b0110, 4'b0000, T_SQ,   B_I4,  1'b0, 1'b1, 4'b0001, 2'd0, 1'b0, "rb_rst");
    step(4'b0010, 4'b0000, T_IDLE, B_SGL, 1'b1, 1'b0, 4'b0010, 2'd0, 1'b0, "rb_arb");

    @(negedge HCLK);
    HBUSREQ = '0;
    HTRANS  = T_IDLE;
    repeat (3) @(posedge HCLK);
    #2;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
